// File: rtl/lsm_backward_sched.sv
// ---------------------------------------------------------------------------
// lsm_backward_sched
//
// Sequencer for the backward-induction pass of the LSM pricer. For every
// exercise step from N_STEPS-1 down to 1 it fetches the step's regression
// coefficients and discount factor, streams each path's spot price through
// the decision datapath (one path per cycle, no bubbles) and writes each
// returned present value into the cash-flow RAM at the matching path address.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             one-cycle start pulse, honoured only when idle
//   busy_o              high from the cycle after an accepted start until done
//   done_o              one-cycle pulse once step 1 has fully drained
//   err_o               sticky flag for unexpected datapath returns
//   cur_step_o          step currently being processed
//   beta_req_o          coefficient request for cur_step_o
//   beta_valid_i        coefficient data valid (handshake with beta_req_o)
//   beta_in_i, disc_in_i    regression coefficients and discount factor
//   beta_out_o, disc_out_o  latched copies, held for the whole step
//   s_rd_en_o, s_rd_addr_o  path-price RAM read port (1-cycle sync RAM)
//   dp_valid_in_o       datapath valid, s_rd_en_o delayed by one cycle
//   dp_valid_out_i, dp_pv_i datapath result (returns in issue order)
//   cf_we_o, cf_addr_o, cf_wdata_o  cash-flow RAM write port
// ---------------------------------------------------------------------------
module lsm_backward_sched #(
   parameter int WIDTH   = 32,
   parameter int N_PATHS = 64,
   parameter int N_STEPS = 16,
   parameter int DP_LAT  = 3,
   parameter int PATH_W  = $clog2(N_PATHS),
   parameter int STEP_W  = $clog2(N_STEPS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic [STEP_W-1:0]        cur_step_o,
   output logic                     beta_req_o,
   input  logic                     beta_valid_i,
   input  logic signed [WIDTH-1:0]  beta_in_i [0:2],
   input  logic signed [WIDTH-1:0]  disc_in_i,
   output logic signed [WIDTH-1:0]  beta_out_o [0:2],
   output logic signed [WIDTH-1:0]  disc_out_o,
   output logic                     s_rd_en_o,
   output logic [PATH_W-1:0]        s_rd_addr_o,
   output logic                     dp_valid_in_o,
   input  logic                     dp_valid_out_i,
   input  logic signed [WIDTH-1:0]  dp_pv_i,
   output logic                     cf_we_o,
   output logic [PATH_W-1:0]        cf_addr_o,
   output logic signed [WIDTH-1:0]  cf_wdata_o
);

   typedef enum logic [2:0] {
      IDLE,
      BETA_WAIT,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   // The return counter must be able to hold N_PATHS itself, one bit wider
   // than a path address.
   localparam int RET_W = PATH_W + 1;

   localparam logic [PATH_W-1:0] ISS_LAST  = PATH_W'(N_PATHS - 1);
   localparam logic [RET_W-1:0]  RET_FULL  = RET_W'(N_PATHS);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_STEPS - 1);
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

   // Elaboration-time guards on the legal parameter range.
   generate
      if (N_PATHS < 2) begin : g_bad_paths
         $error("lsm_backward_sched: N_PATHS must be at least 2");
      end
      if (N_STEPS < 2) begin : g_bad_steps
         $error("lsm_backward_sched: N_STEPS must be at least 2");
      end
      if (DP_LAT < 1) begin : g_bad_lat
         $error("lsm_backward_sched: DP_LAT must be at least 1");
      end
   endgenerate

   // Control state.
   state_t                    state_q,  state_d;
   logic [STEP_W-1:0]         step_q,   step_d;
   logic [PATH_W-1:0]         iss_q,    iss_d;
   logic [RET_W-1:0]          ret_q,    ret_d;
   logic                      err_q,    err_d;
   logic signed [WIDTH-1:0]   beta_q [0:2];
   logic signed [WIDTH-1:0]   beta_d [0:2];
   logic signed [WIDTH-1:0]   disc_q,   disc_d;

   // Registered outputs.
   logic                      busy_q,      busy_d;
   logic                      done_q,      done_d;
   logic                      beta_req_q,  beta_req_d;
   logic                      s_rd_en_q,   s_rd_en_d;
   logic [PATH_W-1:0]         s_rd_addr_q, s_rd_addr_d;
   logic                      dp_valid_q,  dp_valid_d;
   logic                      cf_we_q,     cf_we_d;
   logic [PATH_W-1:0]         cf_addr_q,   cf_addr_d;
   logic signed [WIDTH-1:0]   cf_wdata_q,  cf_wdata_d;

   logic                      beta_hs;

   assign beta_hs = beta_req_q && beta_valid_i;

   // Next-state logic. Datapath returns are handled first because they can
   // arrive in any state; the state-specific part may then override the
   // return counter (handshake clears it) or err (accepted start clears it).
   // Every registered output is decoded from the next state so that it lines
   // up with the state it belongs to rather than lagging by a cycle.
   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      iss_d      = iss_q;
      ret_d      = ret_q;
      err_d      = err_q;
      beta_d     = beta_q;
      disc_d     = disc_q;
      cf_we_d    = 1'b0;
      cf_addr_d  = cf_addr_q;
      cf_wdata_d = cf_wdata_q;

      if (dp_valid_out_i) begin
         if (state_q == IDLE || ret_q == RET_FULL) begin
            err_d = 1'b1;
         end else begin
            cf_we_d    = 1'b1;
            cf_addr_d  = ret_q[PATH_W-1:0];
            cf_wdata_d = dp_pv_i;
            ret_d      = ret_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = BETA_WAIT;
               step_d  = STEP_LAST;
               err_d   = 1'b0;
            end
         end
         BETA_WAIT: begin
            if (beta_hs) begin
               beta_d  = beta_in_i;
               disc_d  = disc_in_i;
               iss_d   = '0;
               ret_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // The issue counter stops at the last path instead of wrapping.
            if (iss_q == ISS_LAST) begin
               state_d = DRAIN;
            end else begin
               iss_d = iss_q + 1'b1;
            end
         end
         DRAIN: begin
            if (ret_q == RET_FULL) begin
               if (step_q == STEP_ONE) begin
                  state_d = DONE;
               end else begin
                  step_d  = step_q - STEP_ONE;
                  state_d = BETA_WAIT;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d      = (state_d == BETA_WAIT) || (state_d == ISSUE) || (state_d == DRAIN);
      done_d      = (state_d == DONE);
      beta_req_d  = (state_d == BETA_WAIT);
      s_rd_en_d   = (state_d == ISSUE);
      s_rd_addr_d = (state_d == ISSUE) ? iss_d : s_rd_addr_q;
      dp_valid_d  = s_rd_en_q;
   end

   // State and output registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         step_q      <= '0;
         iss_q       <= '0;
         ret_q       <= '0;
         err_q       <= 1'b0;
         beta_q      <= '{default: '0};
         disc_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         beta_req_q  <= 1'b0;
         s_rd_en_q   <= 1'b0;
         s_rd_addr_q <= '0;
         dp_valid_q  <= 1'b0;
         cf_we_q     <= 1'b0;
         cf_addr_q   <= '0;
         cf_wdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         iss_q       <= iss_d;
         ret_q       <= ret_d;
         err_q       <= err_d;
         beta_q      <= beta_d;
         disc_q      <= disc_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         beta_req_q  <= beta_req_d;
         s_rd_en_q   <= s_rd_en_d;
         s_rd_addr_q <= s_rd_addr_d;
         dp_valid_q  <= dp_valid_d;
         cf_we_q     <= cf_we_d;
         cf_addr_q   <= cf_addr_d;
         cf_wdata_q  <= cf_wdata_d;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;
   assign cur_step_o    = step_q;
   assign beta_req_o    = beta_req_q;
   assign beta_out_o    = beta_q;
   assign disc_out_o    = disc_q;
   assign s_rd_en_o     = s_rd_en_q;
   assign s_rd_addr_o   = s_rd_addr_q;
   assign dp_valid_in_o = dp_valid_q;
   assign cf_we_o       = cf_we_q;
   assign cf_addr_o     = cf_addr_q;
   assign cf_wdata_o    = cf_wdata_q;

endmodule

// File: doc/lsm_backward_sched.md
# lsm_backward_sched

Sequencer for the backward-induction pass of the LSM pricer. For each exercise step from `N_STEPS-1` down to 1 it fetches that step's regression coefficients and discount factor, streams every path's spot price through the per-path decision datapath, and writes the returned present value into the cash-flow memory at the matching path address. It sits between the regression engine (coefficient source), the path-price RAM, the decision datapath and the cash-flow RAM, and reports completion to the top-level controller.

## Interface
- `WIDTH`, `fpga_cfg_pkg::FP_WIDTH`: fixed-point word width.
- `N_PATHS`, 64: paths per step; must be ≥ 2.
- `N_STEPS`, 16: time steps; steps processed are `N_STEPS-1` … 1; must be ≥ 2.
- `DP_LAT`, 3: fixed cycles from `dp_valid_in` to `dp_valid_out` of the decision datapath; must be ≥ 1.
- `PATH_W`, `$clog2(N_PATHS)`; `STEP_W`, `$clog2(N_STEPS)`: derived widths.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle start pulse; ignored unless idle.
- `busy` out 1: high from the cycle after accepted `start` until `done`.
- `done` out 1: one-cycle pulse when step 1 has fully drained.
- `err` out 1: sticky; set on an unexpected datapath return; cleared only by reset or accepted `start`.
- `cur_step` out STEP_W: step currently being processed.
- `beta_req` out 1: request for coefficients of `cur_step`.
- `beta_valid` in 1: coefficient/discount data valid; accepted when `beta_req && beta_valid`.
- `beta_in[0:2]` in WIDTH×3 signed: regression coefficients.
- `disc_in` in WIDTH signed: discount factor for the step.
- `beta_out[0:2]` out WIDTH×3 signed, `disc_out` out WIDTH signed: latched values, held for the entire step.
- `s_rd_en` out 1, `s_rd_addr` out PATH_W: path-price RAM read; data appears on the datapath `S_t` one cycle later (1-cycle synchronous RAM).
- `dp_valid_in` out 1: datapath valid, equal to `s_rd_en` delayed one cycle.
- `dp_valid_out` in 1, `dp_pv` in WIDTH signed: datapath result.
- `cf_we` out 1, `cf_addr` out PATH_W, `cf_wdata` out WIDTH signed: cash-flow RAM write port.

## Operation
- States: IDLE, BETA_WAIT, ISSUE, DRAIN, DONE.
- IDLE: `start` sets `cur_step = N_STEPS-1`, clears `err`, and moves to BETA_WAIT.
- BETA_WAIT: `beta_req = 1`. On handshake, latch `beta_in`/`disc_in` into `beta_out`/`disc_out`, clear the issue counter and return counter, and go to ISSUE.
- ISSUE: assert `s_rd_en` every cycle with `s_rd_addr` = issue counter 0 … `N_PATHS-1`, one path per cycle with no bubbles. After issuing `N_PATHS-1`, go to DRAIN.
- DRAIN: wait until the return counter reaches `N_PATHS`. Then, if `cur_step == 1`, go to DONE; otherwise decrement `cur_step` and go to BETA_WAIT.
- DONE: pulse `done` for one cycle, then go to IDLE.
- Returns: each `dp_valid_out` produces a registered write next cycle: `cf_we = 1`, `cf_addr` = return counter, `cf_wdata = dp_pv`; the return counter then increments. Results return in order, so the return counter is the path tag.
- Returns are counted in any non-IDLE state. A `dp_valid_out` received while the return counter already equals `N_PATHS`, or while in IDLE, sets `err` and produces no write.
- `start` while `busy` is ignored.
- Reset mid-operation: everything returns to IDLE with outputs at reset values. Late datapath returns after reset while in IDLE set `err`; the verifier must account for this.
- Counters never wrap: the issue counter saturates at the end of ISSUE.

## Timing
- Reset values: `busy`, `done`, `err`, `beta_req`, `s_rd_en`, `dp_valid_in`, `cf_we` = 0; `cur_step`, `s_rd_addr`, `cf_addr`, `cf_wdata`, `beta_out`, `disc_out` = 0.
- `start` at cycle 0 gives `busy` = 1 and `beta_req` = 1 at cycle 1.
- Handshake at cycle h:
  - `beta_out` is valid at h+1.
  - First `s_rd_en` at h+1, first `dp_valid_in` at h+2.
  - First return at h+2+DP_LAT, first `cf_we` at h+3+DP_LAT.
- Per-step cycles excluding beta wait: `N_PATHS + DP_LAT + 3`.
- `beta_out`/`disc_out` are stable from h+1 until the next handshake, so they cover all in-flight paths.
- `done` is asserted in the cycle after the last step-1 `cf_we`; `busy` falls in the same cycle.

## Test plan
- `N_PATHS=4`, `N_STEPS=3`, `DP_LAT=3`, `beta_valid` tied high, datapath model returns `pv = addr+100` → writes (0,100),(1,101),(2,102),(3,103) for step 2 then step 1; `done` exactly once; `busy` cycle count matches the Timing formula.
- `beta_valid` held low 10 cycles at step 1 → no `s_rd_en` during the wait; `beta_out` latched = {0x100, 0x200, 0x300} is held unchanged across all 4 step-1 datapath inputs.
- `start` pulsed mid-run (cycle 7) → ignored; write sequence and `done` timing are identical to the first scenario.
- Extra `dp_valid_out` injected after 4 returns → `err` = 1, no 5th `cf_we`; next `start` clears `err`.
- `rst_n` asserted during ISSUE of step 2 → all outputs at reset values immediately; a new `start` restarts at step 2 with address 0.
- Random stress: `N_PATHS=64`, `N_STEPS=16`, random `beta_valid` gaps → exactly 64×15 writes, every address written once per step in ascending order, `err` = 0.
